edge_fetch_unit: RTL and testbench
==================================

Name: edge_fetch_unit

Overview:
- Upstream memory-fetch stage for the Dijkstra relaxation core.
- For one node index it reads that node's CSR row bounds from the offset table, then reads each (neighbour, weight) edge pair from the edge array.
- Edges go out as a valid/ready stream through a small FIFO; the consumer stage holds the shortest_distance state.
- One memory read is outstanding at a time, on the same 16-bit Avalon-style read interface as the rest of the accelerator.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2).
- ADDR_W, 32, byte-address width of mem_addr.

Ports:
- algorithm_clock  in  1  sole clock.
- algorithm_reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- node_index  in  16  node whose edges are fetched; latched on start.
- offset_base  in  32  byte address of the 16-bit offset table; latched on start.
- edge_base  in  32  byte address of the edge array; latched on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job completion.
- edge_count  out  16  edges in the current row; valid from RD_END completion, held until next start.
- mem_read_enable  out  1  read request.
- mem_write_enable  out  1  tied 0.
- mem_addr  out  ADDR_W  read byte address.
- mem_write_data  out  16  tied 0.
- mem_read_data  in  16  returned data.
- mem_read_ready  in  1  one-cycle data-valid strobe.
- wait_request  in  1  slave stall; request held while high.
- edge_valid  out  1  FIFO head valid.
- edge_ready  in  1  consumer accepts head.
- edge_neighbour  out  16  head neighbour id.
- edge_weight  out  16  head edge weight.
- edge_last  out  1  head is the final edge of the row.

Behaviour:
Reset (algorithm_reset=0, async):
- State IDLE; FIFO emptied.
- busy, done, mem_read_enable, edge_valid, edge_last = 0.
- mem_addr, edge_count, edge_neighbour, edge_weight = 0.

Addressing (byte addresses, modulo 2^32):
- Row start at offset_base + 2*node_index.
- Row end at offset_base + 2*node_index + 2.
- Neighbour of edge e at edge_base + 4*e; its weight at edge_base + 4*e + 2.
- e is 16-bit unsigned.

Memory read handshake:
- Drive mem_read_enable=1 with a stable mem_addr.
- The request is accepted on the first rising edge where wait_request=0; mem_read_enable drops the next cycle.
- Then wait for mem_read_ready=1 and capture mem_read_data on that edge.
- mem_read_ready outside a wait phase is ignored, including after a reset mid-read.

State machine:
- IDLE: start=1 → latch inputs, go to RD_START; busy=1 next cycle.
- RD_START: read row start → e_cur. Then RD_END.
- RD_END: read row end → e_end. edge_count = e_end − e_cur if e_end > e_cur, else 0. If edge_count=0 → DONE, otherwise CHECK.
- CHECK: if the FIFO has a free slot (counting the entry reserved for this edge) → RD_NBR, else stay. No read is issued while the FIFO is full.
- RD_NBR: read the neighbour into a holding register.
- RD_WT: read the weight.
- Edge push: on the weight's mem_read_ready edge, push {last=(e_cur+1==e_end), nbr, wt} and increment e_cur. If last → DRAIN, else CHECK.
- DRAIN: wait until the FIFO is empty (the consumer has accepted the last edge) → DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.

FIFO:
- Pop occurs when edge_valid && edge_ready.
- Simultaneous push and pop while full-minus-reserve is legal; occupancy is unchanged.
- edge_* outputs reflect the FIFO head combinationally from registered storage.
- edge_valid=0 when empty.
- Head data must stay stable while edge_valid=1 and edge_ready=0.
- Read/write pointers wrap modulo FIFO_DEPTH.

Other rules:
- start while busy is ignored; no queuing.
- Latency with zero wait states and 1-cycle read latency: start → first edge_valid in ≤ 12 cycles.
- Throughput is bounded by two reads per edge.

Test Plan:
- Node 2, offset_base 0x1000; table[2]=5, table[3]=7; edge_base 0x2000 with 0x2014={9,30} and 0x2018={4,12}; edge_ready=1 → reads at 0x1004, 0x1006, 0x2014, 0x2016, 0x2018, 0x201A in that order. Outputs (9,30,last=0) then (4,12,last=1); edge_count=2; single done pulse.
- table[n]=table[n+1]=8 (and separately 9 then 3) → edge_count=0, no edge_valid, done two reads after start, no edge-array reads.
- 6-edge row, edge_ready=0 → exactly FIFO_DEPTH=4 entries buffered and no further mem_read_enable. Then edge_ready=1 → remaining 2 delivered in order and done only after the last pop.
- wait_request held high 3 cycles on each request → mem_read_enable and mem_addr stable throughout; one-cycle deassert after acceptance; data unchanged from the zero-wait case.
- algorithm_reset pulled low mid-RD_NBR with 2 entries in FIFO, then a stale mem_read_ready after release → all outputs at reset values, FIFO empty, stale strobe ignored. A subsequent start completes correctly.
- start pulsed during busy → ignored. edge_count and latched node_index unchanged; a second start after done is accepted.

Source files
------------

// File: rtl/edge_fetch_unit.sv
// Edge fetch stage: reads one node's CSR row bounds, then each (neighbour, weight)
// pair, and streams the edges to the relaxation core through a small FIFO.
//
// state    | meaning
// IDLE     | waiting for start
// RD_START | reading row start offset into e_cur
// RD_END   | reading row end offset, computing edge_count
// CHECK    | waiting for a free FIFO slot before fetching the next edge
// RD_NBR   | reading neighbour id into the holding register
// RD_WT    | reading edge weight; edge pushed when the data returns
// DRAIN    | waiting for the consumer to empty the FIFO
// DONE     | one-cycle completion pulse

module edge_fetch_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              algorithm_clock,
    input  logic              algorithm_reset,
    input  logic              start,
    input  logic [15:0]       node_index,
    input  logic [31:0]       offset_base,
    input  logic [31:0]       edge_base,
    output logic              busy,
    output logic              done,
    output logic [15:0]       edge_count,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_write_data,
    input  logic [15:0]       mem_read_data,
    input  logic              mem_read_ready,
    input  logic              wait_request,
    output logic              edge_valid,
    input  logic              edge_ready,
    output logic [15:0]       edge_neighbour,
    output logic [15:0]       edge_weight,
    output logic              edge_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_START, S_RD_END, S_CHECK, S_RD_NBR, S_RD_WT, S_DRAIN, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        rd_wait;
    logic [15:0] node_q;
    logic [31:0] offset_base_q, edge_base_q;
    logic [15:0] e_cur, e_end, nbr_hold, edge_count_q;
    logic [31:0] addr_full;

    logic [32:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    logic is_read_state, rd_done, req_accept, push, pop, fifo_empty, fifo_has_room, last_edge;
    logic [32:0] head;

    assign is_read_state = (state == S_RD_START) || (state == S_RD_END) ||
                           (state == S_RD_NBR) || (state == S_RD_WT);
    assign mem_read_enable  = is_read_state && !rd_wait;
    assign req_accept       = mem_read_enable && !wait_request;
    // A data strobe only counts while a request has been accepted and is awaiting data.
    assign rd_done          = is_read_state && rd_wait && mem_read_ready;
    assign mem_write_enable = 1'b0;
    assign mem_write_data   = '0;

    assign fifo_empty    = (fifo_cnt == '0);
    assign fifo_has_room = (fifo_cnt < CNT_W'(FIFO_DEPTH));
    assign last_edge     = ((e_cur + 16'd1) == e_end);
    assign push          = (state == S_RD_WT) && rd_done;
    assign pop           = edge_valid && edge_ready;

    assign head           = fifo_mem[rd_ptr];
    assign edge_valid     = !fifo_empty;
    assign edge_last      = edge_valid ? head[32] : 1'b0;
    assign edge_neighbour = edge_valid ? head[31:16] : '0;
    assign edge_weight    = edge_valid ? head[15:0] : '0;

    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign edge_count = edge_count_q;

    always_comb begin
        addr_full = '0;
        case (state)
            S_RD_START: addr_full = offset_base_q + {15'd0, node_q, 1'b0};
            S_RD_END:   addr_full = offset_base_q + {15'd0, node_q, 1'b0} + 32'd2;
            S_RD_NBR:   addr_full = edge_base_q + {14'd0, e_cur, 2'b00};
            S_RD_WT:    addr_full = edge_base_q + {14'd0, e_cur, 2'b00} + 32'd2;
            default:    addr_full = '0;
        endcase
        mem_addr = ADDR_W'(addr_full);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_RD_START;
            S_RD_START: if (rd_done) state_nxt = S_RD_END;
            S_RD_END:   if (rd_done) state_nxt = (mem_read_data > e_cur) ? S_CHECK : S_DONE;
            S_CHECK:    if (fifo_has_room) state_nxt = S_RD_NBR;
            S_RD_NBR:   if (rd_done) state_nxt = S_RD_WT;
            S_RD_WT:    if (rd_done) state_nxt = last_edge ? S_DRAIN : S_CHECK;
            S_DRAIN:    if (fifo_empty) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge algorithm_clock or negedge algorithm_reset) begin
        if (!algorithm_reset) begin
            state         <= S_IDLE;
            rd_wait       <= 1'b0;
            node_q        <= '0;
            offset_base_q <= '0;
            edge_base_q   <= '0;
            e_cur         <= '0;
            e_end         <= '0;
            nbr_hold      <= '0;
            edge_count_q  <= '0;
        end else begin
            state <= state_nxt;
            if (rd_done)
                rd_wait <= 1'b0;
            else if (req_accept)
                rd_wait <= 1'b1;
            if (state == S_IDLE && start) begin
                node_q        <= node_index;
                offset_base_q <= offset_base;
                edge_base_q   <= edge_base;
                edge_count_q  <= '0;
            end
            if (state == S_RD_START && rd_done)
                e_cur <= mem_read_data;
            if (state == S_RD_END && rd_done) begin
                e_end        <= mem_read_data;
                edge_count_q <= (mem_read_data > e_cur) ? (mem_read_data - e_cur) : 16'd0;
            end
            if (state == S_RD_NBR && rd_done)
                nbr_hold <= mem_read_data;
            if (push)
                e_cur <= e_cur + 16'd1;
        end
    end

    // CHECK only proceeds with a free slot and nothing else pushes meanwhile, so a push never overflows.
    always_ff @(posedge algorithm_clock or negedge algorithm_reset) begin
        if (!algorithm_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge algorithm_clock) begin
        if (push)
            fifo_mem[wr_ptr] <= {last_edge, nbr_hold, mem_read_data};
    end

endmodule

// File: tb/tb_edge_fetch_unit.sv
// Self-checking bench for edge_fetch_unit: directed CSR scenarios plus randomized jobs
// against a row-level reference model and a behavioural memory slave.

module tb_edge_fetch_unit;

    logic        algorithm_clock = 1'b0;
    logic        algorithm_reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] node_index = '0;
    logic [31:0] offset_base = '0, edge_base = '0;
    logic        busy, done, mem_read_enable, mem_write_enable;
    logic [15:0] edge_count, mem_write_data;
    logic [31:0] mem_addr;
    logic [15:0] mem_read_data = '0;
    logic        mem_read_ready = 1'b0, wait_request = 1'b0;
    logic        edge_valid, edge_ready = 1'b0, edge_last;
    logic [15:0] edge_neighbour, edge_weight;

    always #5 algorithm_clock = ~algorithm_clock;

    edge_fetch_unit #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
        .algorithm_clock(algorithm_clock), .algorithm_reset(algorithm_reset),
        .start(start), .node_index(node_index), .offset_base(offset_base), .edge_base(edge_base),
        .busy(busy), .done(done), .edge_count(edge_count),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_read_ready(mem_read_ready), .wait_request(wait_request),
        .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_neighbour(edge_neighbour),
        .edge_weight(edge_weight), .edge_last(edge_last)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sparse memory: unwritten words return an address hash so every edge is well defined.
    logic [15:0] mem [logic [31:0]];
    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ a[31:16] ^ 16'h3C5A;
    endfunction

    // Memory slave, driven on the falling edge so the DUT sees stable inputs.
    bit          in_req = 0, resp_due = 0, just_acc = 0;
    int          stall_left = 0, resp_idx = 0, drop_at_req = -1;
    int          ws_fixed = 0;
    bit          ws_rand = 0;
    int          stale_req = 0, stale_done = 0;
    logic [31:0] req_addr = '0, resp_addr = '0;
    logic [31:0] req_log [$];

    always @(negedge algorithm_clock) begin
        mem_read_ready = 1'b0;
        wait_request   = 1'b0;
        mem_read_data  = 16'($urandom);
        if (!algorithm_reset) begin
            in_req = 0; resp_due = 0; just_acc = 0;
        end else begin
            if (stale_req != stale_done) begin
                stale_done = stale_req;
                mem_read_ready = 1'b1;
                mem_read_data  = 16'hDEAD;
            end
            if (resp_due) begin
                resp_due = 0;
                if (resp_idx != drop_at_req) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem_rd(resp_addr);
                end
            end
            if (just_acc) begin
                just_acc = 0;
                check("rd_en_drop_after_accept", 64'(mem_read_enable), 64'(0));
            end
            if (mem_read_enable) begin
                if (!in_req) begin
                    in_req = 1;
                    req_addr = mem_addr;
                    req_log.push_back(mem_addr);
                    stall_left = ws_rand ? int'($urandom_range(0, 3)) : ws_fixed;
                end else begin
                    check("addr_stable_in_stall", 64'(mem_addr), 64'(req_addr));
                end
                if (stall_left > 0) begin
                    wait_request = 1'b1;
                    stall_left--;
                end else begin
                    in_req = 0; just_acc = 1; resp_due = 1;
                    resp_addr = req_addr;
                    resp_idx = req_log.size() - 1;
                end
            end else if (in_req) begin
                check("rd_en_held_in_stall", 64'(mem_read_enable), 64'(1));
                in_req = 0;
            end
        end
    end

    // Consumer-side monitor: records pops, checks head stability and done behaviour.
    logic [32:0] got [$];
    int          done_cnt = 0, edges_at_done = 0;
    bit          hold_v = 0;
    logic [32:0] hold_head = '0;

    always @(negedge algorithm_clock) begin
        if (edge_valid && edge_ready)
            got.push_back({edge_last, edge_neighbour, edge_weight});
        if (edge_valid && !edge_ready) begin
            if (hold_v)
                check("head_stable", 64'({edge_last, edge_neighbour, edge_weight}), 64'(hold_head));
            hold_v = 1;
            hold_head = {edge_last, edge_neighbour, edge_weight};
        end else begin
            hold_v = 0;
        end
        if (done) begin
            done_cnt++;
            edges_at_done = got.size();
            check("busy_low_at_done", 64'(busy), 64'(0));
        end
    end

    logic [31:0] exp_addr [$];
    logic [32:0] exp_edge [$];
    logic [15:0] exp_count;
    int base_r, base_g, base_d;

    task automatic tick();
        @(posedge algorithm_clock);
        #1;
    endtask

    // Reference model: a row is [table[n], table[n+1]); each edge costs two word reads.
    task automatic start_job(input logic [15:0] node, input logic [31:0] ob, input logic [31:0] eb);
        logic [31:0] a0, na;
        logic [15:0] s, e, ek;
        a0 = ob + {15'd0, node, 1'b0};
        s = mem_rd(a0);
        e = mem_rd(a0 + 32'd2);
        exp_addr.delete();
        exp_edge.delete();
        exp_addr.push_back(a0);
        exp_addr.push_back(a0 + 32'd2);
        exp_count = (e > s) ? e - s : 16'd0;
        for (int k = 0; k < int'(exp_count); k++) begin
            ek = s + 16'(k);
            na = eb + {14'd0, ek, 2'b00};
            exp_addr.push_back(na);
            exp_addr.push_back(na + 32'd2);
            exp_edge.push_back({k == int'(exp_count) - 1, mem_rd(na), mem_rd(na + 32'd2)});
        end
        base_r = req_log.size();
        base_g = got.size();
        base_d = done_cnt;
        start = 1'b1; node_index = node; offset_base = ob; edge_base = eb;
        tick();
        start = 1'b0; node_index = 16'($urandom); offset_base = $urandom; edge_base = $urandom;
    endtask

    task automatic finish_job(input int rmode, input int glitch_at, input string tag, output int first_valid);
        int cyc, n;
        first_valid = -1;
        for (cyc = 1; cyc < 3000; cyc++) begin
            if (done_cnt > base_d) break;
            if (first_valid < 0 && edge_valid) first_valid = cyc;
            start = (cyc == glitch_at);
            if (cyc == glitch_at) begin
                node_index = 16'($urandom); offset_base = $urandom; edge_base = $urandom;
            end
            edge_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : 1'b0;
            tick();
        end
        start = 1'b0;
        edge_ready = 1'b1;
        repeat (3) tick();
        check({tag, "_done_pulses"}, 64'(done_cnt - base_d), 64'(1));
        check({tag, "_busy_idle"}, 64'(busy), 64'(0));
        check({tag, "_edge_count"}, 64'(edge_count), 64'(exp_count));
        check({tag, "_nreads"}, 64'(req_log.size() - base_r), 64'(exp_addr.size()));
        n = req_log.size() - base_r;
        for (int i = 0; i < n && i < exp_addr.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 64'(req_log[base_r + i]), 64'(exp_addr[i]));
        check({tag, "_nedges"}, 64'(got.size() - base_g), 64'(exp_edge.size()));
        n = got.size() - base_g;
        for (int i = 0; i < n && i < exp_edge.size(); i++)
            check($sformatf("%s_edge%0d", tag, i), 64'(got[base_g + i]), 64'(exp_edge[i]));
        if (exp_edge.size() > 0)
            check({tag, "_done_after_last_pop"}, 64'(edges_at_done - base_g), 64'(exp_edge.size()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, mem_read_enable, mem_write_enable, edge_valid, edge_last}), 64'(0));
        check({tag, "_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_count"}, 64'(edge_count), 64'(0));
        check({tag, "_head"}, 64'({edge_neighbour, edge_weight, mem_write_data}), 64'(0));
    endtask

    initial begin
        int fv, found;
        logic [15:0] nd, s;
        logic [31:0] ob, eb;

        repeat (3) tick();
        check_reset_outputs("reset");
        algorithm_reset = 1'b1;
        edge_ready = 1'b1;
        tick();

        // Worked example from the row layout: two edges, zero wait states.
        mem[32'h1004] = 16'd5;  mem[32'h1006] = 16'd7;
        mem[32'h2014] = 16'd9;  mem[32'h2016] = 16'd30;
        mem[32'h2018] = 16'd4;  mem[32'h201A] = 16'd12;
        start_job(16'd2, 32'h1000, 32'h2000);
        finish_job(0, -1, "basic", fv);
        check("basic_latency_le12", 64'(fv > 0 && fv <= 12), 64'(1));

        // Empty rows: equal bounds and inverted bounds.
        mem[32'h5000] = 16'd8; mem[32'h5002] = 16'd8;
        start_job(16'd0, 32'h5000, 32'h2000);
        finish_job(0, -1, "empty_eq", fv);
        check("empty_eq_no_valid", 64'(fv), 64'(-1));
        mem[32'h5008] = 16'd9; mem[32'h500A] = 16'd3;
        start_job(16'd4, 32'h5000, 32'h2000);
        finish_job(0, -1, "empty_inv", fv);
        check("empty_inv_no_valid", 64'(fv), 64'(-1));

        // Consumer stalled: FIFO fills to depth and fetching stops.
        mem[32'h3002] = 16'd10; mem[32'h3004] = 16'd16;
        edge_ready = 1'b0;
        start_job(16'd1, 32'h3000, 32'h4000);
        repeat (80) tick();
        check("stall_reads_issued", 64'(req_log.size() - base_r), 64'(10));
        check("stall_no_rd_en", 64'(mem_read_enable), 64'(0));
        check("stall_valid", 64'({edge_valid, busy}), 64'(2'b11));
        check("stall_no_pops", 64'(got.size() - base_g), 64'(0));
        finish_job(0, -1, "stall6", fv);

        // Three wait states per request; data identical to the zero-wait case.
        ws_fixed = 3;
        start_job(16'd2, 32'h1000, 32'h2000);
        finish_job(0, -1, "ws3", fv);
        ws_fixed = 0;

        // Reset mid neighbour read with two entries buffered, then a stale strobe.
        mem[32'h6006] = 16'd100; mem[32'h6008] = 16'd106;
        edge_ready = 1'b0;
        start_job(16'd3, 32'h6000, 32'h7000);
        drop_at_req = base_r + 6;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (req_log.size() > base_r + 6) begin found = 1; break; end
            tick();
        end
        check("rst_reached_rd_nbr", 64'(found), 64'(1));
        repeat (3) tick();
        check("rst_two_buffered", 64'({edge_valid, busy}), 64'(2'b11));
        algorithm_reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) tick();
        algorithm_reset = 1'b1;
        drop_at_req = -1;
        base_r = req_log.size();
        base_d = done_cnt;
        stale_req++;
        repeat (5) tick();
        check("stale_ignored_ctl", 64'({busy, mem_read_enable, edge_valid}), 64'(0));
        check("stale_no_reads", 64'(req_log.size() - base_r), 64'(0));
        check("stale_no_done", 64'(done_cnt - base_d), 64'(0));
        edge_ready = 1'b1;
        start_job(16'd3, 32'h6000, 32'h7000);
        finish_job(1, -1, "after_rst", fv);

        // Start while busy is ignored; next start after done is accepted.
        ws_fixed = 1;
        start_job(16'd2, 32'h1000, 32'h2000);
        finish_job(0, 4, "glitch", fv);
        start_job(16'd1, 32'h3000, 32'h4000);
        finish_job(0, -1, "second_start", fv);
        ws_fixed = 0;

        // Randomized jobs, including address wrap at the top of the 32-bit space.
        ws_rand = 1;
        for (int it = 0; it < 8; it++) begin
            nd = 16'($urandom_range(0, 500));
            ob = $urandom & 32'hFFFF_FFFE;
            eb = $urandom & 32'hFFFF_FFFE;
            s  = 16'($urandom_range(0, 60000));
            if (it == 2) ob = 32'hFFFF_FFFE - {15'd0, nd, 1'b0};
            if (it == 5) eb = 32'hFFFF_FFF0 - {14'd0, s, 2'b00};
            mem[ob + {15'd0, nd, 1'b0}] = s;
            case ($urandom_range(0, 9))
                0:       mem[ob + {15'd0, nd, 1'b0} + 32'd2] = s;
                1:       mem[ob + {15'd0, nd, 1'b0} + 32'd2] = s - 16'd1;
                default: mem[ob + {15'd0, nd, 1'b0} + 32'd2] = s + 16'($urandom_range(1, 6));
            endcase
            start_job(nd, ob, eb);
            finish_job(1, -1, $sformatf("rnd%0d", it), fv);
        end
        ws_rand = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
